vx_timeit_csr: RTL and testbench

CSR-side timed-region profiler in the commit-to-CSR path, directly downstream of the commit stage. It owns the timed-region start/end PC registers and the enable bit, and drives them back to commit. It consumes commit's per-warp `timeit_active` mask and per-cycle `commit_size`, and accumulates 64-bit cycle and instruction counts for the region. Software programs and reads the block through a small CSR window.

---
 rtl/vx_timeit_csr.sv | 187 ++++++++++++++++++
 tb/tb_vx_timeit_csr.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_timeit_csr.sv
// vx_timeit_csr: timed-region profiler on the commit-to-CSR path.
// Holds the region start/end PCs and enable for commit, and counts cycles
// and retired instructions while any warp is inside the region. Software
// controls and reads it through an 8-entry CSR window at CSR_BASE.
module vx_timeit_csr #(
  parameter int          NUM_WARPS = 4,
  parameter int          COMMIT_W  = 5,
  parameter logic [11:0] CSR_BASE  = 12'h7C0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmt_valid,
  input  logic [COMMIT_W-1:0]  cmt_commit_size,
  input  logic [NUM_WARPS-1:0] cmt_timeit_active,
  output logic [31:0]          timeit_start_addr,
  output logic [31:0]          timeit_end_addr,
  output logic                 timeit_enable,
  input  logic                 csr_write_valid,
  input  logic [11:0]          csr_write_addr,
  input  logic [31:0]          csr_write_data,
  input  logic                 csr_read_valid,
  input  logic [11:0]          csr_read_addr,
  output logic [31:0]          csr_read_data,
  output logic                 csr_read_data_valid,
  output logic                 timeit_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] cyc_q, cyc_d;
  logic [63:0] ins_q, ins_d;
  logic        done_q, done_d;
  logic        enable_q;
  logic [31:0] start_q, end_q;
  logic [31:0] cyc_shadow_q, ins_shadow_q;
  logic [31:0] read_data_q;
  logic        read_valid_q;

  // Window decode: subtracting the base first keeps the test wrap-safe.
  logic [11:0] wr_off, rd_off;
  logic        wr_in, rd_in;
  logic        ctrl_wr, ctrl_en, ctrl_clr;
  logic        any_active, live;
  logic [31:0] rd_mux;

  assign wr_off     = csr_write_addr - CSR_BASE;
  assign rd_off     = csr_read_addr - CSR_BASE;
  assign wr_in      = csr_write_valid && (wr_off < 12'd8);
  assign rd_in      = rd_off < 12'd8;
  assign ctrl_wr    = wr_in && (wr_off[2:0] == 3'd2);
  assign ctrl_en    = csr_write_data[0];
  assign ctrl_clr   = csr_write_data[1];
  assign any_active = |cmt_timeit_active;
  assign live       = (state_q == ARMED) || (state_q == RUNNING);

  // Next-state and counter update: counting first, then CTRL writes override it.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    done_d  = done_q;
    if (live && any_active) begin
      cyc_d = cyc_q + 64'd1;
      if (cmt_valid) ins_d = ins_q + 64'(cmt_commit_size);
    end
    unique case (state_q)
      IDLE: begin
        if (ctrl_wr && ctrl_en) begin
          state_d = ARMED;
          cyc_d   = '0;
          ins_d   = '0;
        end
      end
      ARMED: begin
        if (ctrl_wr && !ctrl_en) begin
          state_d = IDLE;
          cyc_d   = cyc_q;
          ins_d   = ins_q;
        end else if (any_active) begin
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        if (ctrl_wr && !ctrl_en) begin
          state_d = IDLE;
          cyc_d   = cyc_q;
          ins_d   = ins_q;
        end else if (!any_active) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (ctrl_wr && ctrl_en) begin
          state_d = ARMED;
          cyc_d   = '0;
          ins_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ctrl_wr && ctrl_clr) begin
      cyc_d  = '0;
      ins_d  = '0;
      done_d = 1'b0;
      if (state_q == DONE) state_d = IDLE;
    end
  end

  // Read mux over pre-edge register values; HI entries come from the shadows.
  always_comb begin
    rd_mux = '0;
    if (rd_in) begin
      unique case (rd_off[2:0])
        3'd0: rd_mux = start_q;
        3'd1: rd_mux = end_q;
        3'd2: rd_mux = {30'b0, live, 1'b0};
        3'd3: rd_mux = cyc_q[31:0];
        3'd4: rd_mux = cyc_shadow_q;
        3'd5: rd_mux = ins_q[31:0];
        3'd6: rd_mux = ins_shadow_q;
        3'd7: rd_mux = {28'b0, state_q, done_q, any_active};
        default: rd_mux = '0;
      endcase
    end
  end

  // Profiler state, counters and the commit-facing enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      ins_q    <= '0;
      done_q   <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      ins_q    <= ins_d;
      done_q   <= done_d;
      enable_q <= (state_d == ARMED) || (state_d == RUNNING);
    end
  end

  // Region PCs are locked while a region is armed or running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= '0;
      end_q   <= '0;
    end else if (wr_in && !live) begin
      if (wr_off[2:0] == 3'd0) start_q <= csr_write_data;
      if (wr_off[2:0] == 3'd1) end_q   <= csr_write_data;
    end
  end

  // Read response register plus HI shadows captured on LO reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      cyc_shadow_q <= '0;
      ins_shadow_q <= '0;
    end else begin
      read_valid_q <= csr_read_valid;
      if (csr_read_valid) begin
        read_data_q <= rd_mux;
        if (rd_in && rd_off[2:0] == 3'd3) cyc_shadow_q <= cyc_q[63:32];
        if (rd_in && rd_off[2:0] == 3'd5) ins_shadow_q <= ins_q[63:32];
      end
    end
  end

  assign timeit_start_addr   = start_q;
  assign timeit_end_addr     = end_q;
  assign timeit_enable       = enable_q;
  assign timeit_done         = done_q;
  assign csr_read_data       = read_data_q;
  assign csr_read_data_valid = read_valid_q;

endmodule

// File: tb/tb_vx_timeit_csr.sv
// Testbench for vx_timeit_csr: directed region scenarios plus randomized
// traffic, all checked against a behavioural model of the profiler.
module tb_vx_timeit_csr;

  localparam logic [11:0] BASE = 12'h7C0;
  localparam int          NW   = 4;
  localparam int          CW   = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmt_valid;
  logic [CW-1:0] cmt_commit_size;
  logic [NW-1:0] cmt_timeit_active;
  logic [31:0]   timeit_start_addr, timeit_end_addr;
  logic          timeit_enable;
  logic          csr_write_valid;
  logic [11:0]   csr_write_addr;
  logic [31:0]   csr_write_data;
  logic          csr_read_valid;
  logic [11:0]   csr_read_addr;
  logic [31:0]   csr_read_data;
  logic          csr_read_data_valid;
  logic          timeit_done;

  vx_timeit_csr #(.NUM_WARPS(NW), .COMMIT_W(CW), .CSR_BASE(BASE)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cmt_valid           (cmt_valid),
    .cmt_commit_size     (cmt_commit_size),
    .cmt_timeit_active   (cmt_timeit_active),
    .timeit_start_addr   (timeit_start_addr),
    .timeit_end_addr     (timeit_end_addr),
    .timeit_enable       (timeit_enable),
    .csr_write_valid     (csr_write_valid),
    .csr_write_addr      (csr_write_addr),
    .csr_write_data      (csr_write_data),
    .csr_read_valid      (csr_read_valid),
    .csr_read_addr       (csr_read_addr),
    .csr_read_data       (csr_read_data),
    .csr_read_data_valid (csr_read_data_valid),
    .timeit_done         (timeit_done)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model: phase is 0 idle, 1 armed, 2 running, 3 done.
  int          mPhase;
  logic [63:0] mCycles, mInstr;
  logic        mDone;
  logic [31:0] mStart, mEnd, mCycHi, mInsHi;
  logic        expRdValid;
  logic [31:0] expRdData;
  logic [31:0] lastRd;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    mPhase = 0; mCycles = '0; mInstr = '0; mDone = 1'b0;
    mStart = '0; mEnd = '0; mCycHi = '0; mInsHi = '0;
    expRdValid = 1'b0; expRdData = '0;
  endfunction

  // One clock edge of the profiler, written from the register map and region rules.
  function automatic void modelEdge(input logic [NW-1:0] act, input logic v, input logic [CW-1:0] sz,
                                    input logic wv, input logic [11:0] wa, input logic [31:0] wd,
                                    input logic rv, input logic [11:0] ra);
    int          oldPhase   = mPhase;
    logic [63:0] oldCycles  = mCycles;
    logic [63:0] oldInstr   = mInstr;
    logic        oldDone    = mDone;
    bit          inRegion   = (oldPhase == 1) || (oldPhase == 2);
    logic [11:0] off        = ra - BASE;
    expRdValid = rv;
    if (rv) begin
      expRdData = 32'h0;
      case (off)
        12'd0: expRdData = mStart;
        12'd1: expRdData = mEnd;
        12'd2: expRdData = inRegion ? 32'h2 : 32'h0;
        12'd3: begin expRdData = mCycles[31:0]; mCycHi = mCycles[63:32]; end
        12'd4: expRdData = mCycHi;
        12'd5: begin expRdData = mInstr[31:0]; mInsHi = mInstr[63:32]; end
        12'd6: expRdData = mInsHi;
        12'd7: expRdData = (oldPhase << 2) | (oldDone ? 2 : 0) | ((act != 0) ? 1 : 0);
        default: expRdData = 32'h0;
      endcase
    end
    if (wv && wa == BASE && !inRegion) mStart = wd;
    if (wv && wa == BASE + 12'd1 && !inRegion) mEnd = wd;
    if (inRegion && act != 0) begin
      mCycles = mCycles + 1;
      if (v) mInstr = mInstr + sz;
    end
    if (oldPhase == 1 && act != 0) mPhase = 2;
    if (oldPhase == 2 && act == 0) begin mPhase = 3; mDone = 1'b1; end
    if (wv && wa == BASE + 12'd2) begin
      if (!wd[0] && inRegion) begin
        mPhase = 0; mCycles = oldCycles; mInstr = oldInstr; mDone = oldDone;
      end
      if (wd[0] && (oldPhase == 0 || oldPhase == 3)) begin
        mPhase = 1; mCycles = '0; mInstr = '0; mDone = 1'b0;
      end
      if (wd[1]) begin
        mCycles = '0; mInstr = '0; mDone = 1'b0;
        if (oldPhase == 3) mPhase = 0;
      end
    end
  endfunction

  // Drive one cycle of inputs, advance the model, then check all outputs after the edge.
  task automatic applyStimulus(input logic [NW-1:0] act, input logic v, input logic [CW-1:0] sz,
                               input logic wv, input logic [11:0] wa, input logic [31:0] wd,
                               input logic rv, input logic [11:0] ra);
    @(negedge clk);
    cmt_timeit_active = act; cmt_valid = v; cmt_commit_size = sz;
    csr_write_valid = wv; csr_write_addr = wa; csr_write_data = wd;
    csr_read_valid = rv; csr_read_addr = ra;
    modelEdge(act, v, sz, wv, wa, wd, rv, ra);
    @(posedge clk);
    #1;
    lastRd = csr_read_data;
    checkOutput("rd_valid", csr_read_data_valid, expRdValid);
    if (expRdValid) checkOutput("rd_data", csr_read_data, expRdData);
    checkOutput("done", timeit_done, mDone);
    checkOutput("enable", timeit_enable, (mPhase == 1 || mPhase == 2));
    checkOutput("start", timeit_start_addr, mStart);
    checkOutput("end", timeit_end_addr, mEnd);
  endtask

  task automatic idle(input logic [NW-1:0] act);
    applyStimulus(act, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic csrWrite(input logic [2:0] o, input logic [31:0] d, input logic [NW-1:0] act);
    applyStimulus(act, 1'b0, '0, 1'b1, BASE + 12'(o), d, 1'b0, '0);
  endtask

  task automatic csrRead(input logic [2:0] o, input logic [NW-1:0] act);
    applyStimulus(act, 1'b0, '0, 1'b0, '0, '0, 1'b1, BASE + 12'(o));
  endtask

  initial begin
    reset_n = 1'b0;
    cmt_valid = 1'b0; cmt_commit_size = '0; cmt_timeit_active = '0;
    csr_write_valid = 1'b0; csr_write_addr = '0; csr_write_data = '0;
    csr_read_valid = 1'b0; csr_read_addr = '0;
    modelReset();
    lastRd = '0;
    #1;
    checkOutput("reset_enable", timeit_enable, 0);
    checkOutput("reset_done", timeit_done, 0);
    checkOutput("reset_rdvalid", csr_read_data_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic region: ten active cycles retiring three instructions each.
    csrWrite(3'd0, 32'h100, '0);
    csrWrite(3'd1, 32'h200, '0);
    csrWrite(3'd2, 32'h1, '0);
    for (int i = 0; i < 10; i++) applyStimulus(4'b0001, 1'b1, 5'd3, 1'b0, '0, '0, 1'b0, '0);
    idle('0);
    csrRead(3'd3, '0); checkOutput("basic_cyc_lo", lastRd, 32'd10);
    csrRead(3'd5, '0); checkOutput("basic_ins_lo", lastRd, 32'd30);
    csrRead(3'd7, '0); checkOutput("basic_status", lastRd, 32'hE);
    checkOutput("basic_done", timeit_done, 1);
    checkOutput("basic_enable", timeit_enable, 0);

    // Address lock while armed, unlocked once done.
    csrWrite(3'd2, 32'h1, '0);
    csrWrite(3'd0, 32'h300, '0);
    csrRead(3'd0, '0); checkOutput("lock_armed", lastRd, 32'h100);
    idle(4'b0010); idle(4'b0010); idle('0);
    csrWrite(3'd0, 32'h300, '0);
    csrRead(3'd0, '0); checkOutput("lock_done", lastRd, 32'h300);

    // Counter wrap across 32 bits and the atomic LO/HI read pair.
    csrWrite(3'd2, 32'h1, '0);
    @(negedge clk);
    force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.cyc_q;
    mCycles = 64'h0000_0000_FFFF_FFFF;
    idle(4'b0100);
    csrRead(3'd3, 4'b0100); checkOutput("wrap_lo", lastRd, 32'h0);
    idle(4'b0100); idle(4'b0100);
    csrRead(3'd4, 4'b0100); checkOutput("wrap_hi", lastRd, 32'h1);
    idle('0);

    // Clear+enable on an active cycle: counters zeroed, region armed.
    csrWrite(3'd2, 32'h2, '0);
    csrWrite(3'd2, 32'h3, 4'b1000);
    csrRead(3'd3, '0); checkOutput("simul_cyc", lastRd, 32'h0);
    csrRead(3'd5, '0); checkOutput("simul_ins", lastRd, 32'h0);
    csrRead(3'd7, '0); checkOutput("simul_status", lastRd, 32'h4);

    // Disable after five running cycles: counts hold, back to idle.
    for (int i = 0; i < 5; i++) applyStimulus(4'b0001, 1'b1, 5'd7, 1'b0, '0, '0, 1'b0, '0);
    csrWrite(3'd2, 32'h0, 4'b0001);
    csrRead(3'd3, '0); checkOutput("disable_cyc", lastRd, 32'd5);
    csrRead(3'd7, '0); checkOutput("disable_status", lastRd, 32'h0);
    checkOutput("disable_done", timeit_done, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [NW-1:0] act;
      logic          wv, rv;
      logic [11:0]   wa, ra;
      logic [31:0]   wd;
      int            pick;
      act  = ($urandom_range(0, 3) == 0) ? '0 : NW'($urandom);
      pick = $urandom_range(0, 19);
      wv   = pick < 4;
      wa   = (pick < 2) ? BASE + 12'd2 : BASE + 12'($urandom_range(0, 9));
      wd   = (pick < 2) ? 32'($urandom_range(0, 3)) : $urandom;
      rv   = $urandom_range(0, 1) == 1;
      ra   = ($urandom_range(0, 15) == 0) ? 12'h001 : BASE + 12'($urandom_range(0, 9));
      applyStimulus(act, 1'($urandom), CW'($urandom), wv, wa, wd, rv, ra);
    end

    // Reset in the middle of a running region.
    csrWrite(3'd2, 32'h2, '0);
    csrWrite(3'd2, 32'h1, '0);
    idle(4'b0001); idle(4'b0001);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_start", timeit_start_addr, 0);
    checkOutput("rst_end", timeit_end_addr, 0);
    checkOutput("rst_enable", timeit_enable, 0);
    checkOutput("rst_done", timeit_done, 0);
    checkOutput("rst_rdata", csr_read_data, 0);
    checkOutput("rst_rdvalid", csr_read_data_valid, 0);
    cmt_timeit_active = '0;
    @(negedge clk);
    reset_n = 1'b1;
    csrRead(3'd7, '0); checkOutput("rst_status", lastRd, 32'h0);
    csrRead(3'd3, '0); checkOutput("rst_cyc_lo", lastRd, 32'h0);
    csrRead(3'd4, '0); checkOutput("rst_cyc_hi", lastRd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
